// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris move scheduler.
//   op_code_t     : 3-bit operation code offered to the board datapath
//   sched_state_t : scheduler FSM states
//   BOARD_W/H     : playfield dimensions of the board datapath
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LEFT    = 3'd1,
    OP_RIGHT   = 3'd2,
    OP_ROT_CW  = 3'd3,
    OP_ROT_CCW = 3'd4,
    OP_DROP    = 3'd5,
    OP_SPAWN   = 3'd6
  } op_code_t;

  typedef enum logic [1:0] {
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT,
    ST_GAME_OVER
  } sched_state_t;

endpackage

// File: rtl/tetris_edge_latch.sv
// Rising-edge detector plus a sticky pending bit.
//   clk     : clock
//   resetn  : asynchronous reset, active high
//   level   : button level (already synchronized)
//   rise    : combinational, level went 0 -> 1 this cycle
//   set     : sets the pending bit (owner gates rise with run/game state)
//   clear   : clears the pending bit; set wins when both are high
//   pending : sticky request bit
module tetris_edge_latch (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  input  logic set,
  input  logic clear,
  output logic rise,
  output logic pending
);

  logic level_q;

  assign rise = level & ~level_q;

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      level_q <= 1'b0;
      pending <= 1'b0;
    end else begin
      // The previous level tracks the button even while paused, so a press
      // held across a pause does not fire when the game resumes.
      level_q <= level;
      if (set) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tetris_move_scheduler.sv
// Serializes button presses and gravity into single board operations.
//   clk              : clock, rising edge
//   resetn           : asynchronous reset, active high despite the name
//   run              : 1 = game running, 0 = paused
//   rotate           : rotate button level
//   rotate_direction : 1 = clockwise, 0 = counter-clockwise
//   left, right      : move button levels
//   op_valid/op_code : operation offered to the datapath (registered)
//   op_ready         : datapath accepts the offered operation
//   op_done/op_ok    : completion pulse and applied(1)/blocked(0) status
//   busy             : an operation is offered or in flight
//   game_over        : sticky until reset
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAVITY_PERIOD = 25_000_000,
  parameter int CNT_W          = $clog2(GRAVITY_PERIOD)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic       rotate,
  input  logic       rotate_direction,
  input  logic       left,
  input  logic       right,
  output logic       op_valid,
  output logic [2:0] op_code,
  input  logic       op_ready,
  input  logic       op_done,
  input  logic       op_ok,
  output logic       busy,
  output logic       game_over
);

  sched_state_t     state;
  op_code_t         op_reg;
  op_code_t         next_op;
  logic             any_pend;
  logic [CNT_W-1:0] grav_cnt;
  logic             rot_dir;
  logic             pend_left, pend_right, pend_rot, pend_drop, pend_spawn;
  logic             rise_left, rise_right, rise_rot;

  // Edges and gravity only count while running and not dead.
  logic active;
  logic flush;
  logic handshake;
  logic grav_tick;
  logic lock;

  assign active    = run && (state != ST_GAME_OVER);
  assign flush     = (state == ST_GAME_OVER);
  assign handshake = op_valid & op_ready;
  assign grav_tick = active && (grav_cnt == CNT_W'(GRAVITY_PERIOD - 1));
  // A drop that cannot move means the piece has landed.
  assign lock      = (state == ST_WAIT) && op_done && !op_ok && (op_reg == OP_DROP);

  assign op_code   = op_reg;

  tetris_edge_latch u_left (
    .clk     (clk),
    .resetn  (resetn),
    .level   (left),
    .set     (rise_left && active),
    .clear   ((handshake && op_reg == OP_LEFT) || flush),
    .rise    (rise_left),
    .pending (pend_left)
  );

  tetris_edge_latch u_right (
    .clk     (clk),
    .resetn  (resetn),
    .level   (right),
    .set     (rise_right && active),
    .clear   ((handshake && op_reg == OP_RIGHT) || flush),
    .rise    (rise_right),
    .pending (pend_right)
  );

  tetris_edge_latch u_rot (
    .clk     (clk),
    .resetn  (resetn),
    .level   (rotate),
    .set     (rise_rot && active),
    .clear   ((handshake && (op_reg == OP_ROT_CW || op_reg == OP_ROT_CCW)) || flush),
    .rise    (rise_rot),
    .pending (pend_rot)
  );

  // Gravity counter, drop/spawn requests and the latched rotate direction.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      grav_cnt   <= '0;
      pend_drop  <= 1'b0;
      pend_spawn <= 1'b1;  // first piece spawns straight out of reset
      rot_dir    <= 1'b0;
    end else begin
      if (active) begin
        grav_cnt <= grav_tick ? '0 : grav_cnt + CNT_W'(1);
      end

      if (grav_tick) begin
        pend_drop <= 1'b1;
      end else if ((handshake && op_reg == OP_DROP) || flush) begin
        pend_drop <= 1'b0;
      end

      if (lock) begin
        pend_spawn <= 1'b1;
      end else if ((handshake && op_reg == OP_SPAWN) || flush) begin
        pend_spawn <= 1'b0;
      end

      // Repeat presses while a rotate is pending update the direction.
      if (rise_rot && active) begin
        rot_dir <= rotate_direction;
      end
    end
  end

  // Fixed priority: SPAWN > ROT > LEFT > RIGHT > DROP.
  always_comb begin
    // NOTE: default first so every path assigns next_op and no latch is inferred.
    next_op  = OP_NOP;
    any_pend = pend_spawn | pend_rot | pend_left | pend_right | pend_drop;
    if (pend_spawn) begin
      next_op = OP_SPAWN;
    end else if (pend_rot) begin
      next_op = rot_dir ? OP_ROT_CW : OP_ROT_CCW;
    end else if (pend_left) begin
      next_op = OP_LEFT;
    end else if (pend_right) begin
      next_op = OP_RIGHT;
    end else if (pend_drop) begin
      next_op = OP_DROP;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= ST_SELECT;
      op_valid  <= 1'b0;
      op_reg    <= OP_NOP;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        ST_SELECT: begin
          if (run && any_pend) begin
            op_reg   <= next_op;
            op_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        // The offer stays up even if run drops; only op_ready retires it.
        ST_ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        // Blocked LEFT/RIGHT/ROT are dropped; a blocked DROP raises
        // pend_spawn through lock; a blocked SPAWN ends the game.
        ST_WAIT: begin
          if (op_done) begin
            busy <= 1'b0;
            if (op_reg == OP_SPAWN && !op_ok) begin
              game_over <= 1'b1;
              state     <= ST_GAME_OVER;
            end else begin
              state <= ST_SELECT;
            end
          end
        end
        ST_GAME_OVER: begin
          state <= ST_GAME_OVER;
        end
      endcase
    end
  end

endmodule

// File: doc/tetris_move_scheduler.md
# tetris_move_scheduler

Sequences all piece-movement operations applied to the 10x20 Tetris board datapath. Turns the raw button levels (`left`, `right`, `rotate`, `rotate_direction`) and an internal gravity timer into a serialized stream of single operations. Each operation is issued over a valid/ready handshake and completes with a done/ok report. Also handles piece lock, respawn and game-over.

## Interface
- `GRAVITY_PERIOD`, default 25_000_000: clock cycles between gravity drops; legal range is 2 and up.
- `CNT_W`, default `$clog2(GRAVITY_PERIOD)`: width of the gravity counter.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous, active-high reset (asserted = 1), despite the name.
- `run` in 1: 1 = game running, 0 = paused.
- `rotate` in 1: rotate button level; pre-synchronized.
- `rotate_direction` in 1: 1 = clockwise, 0 = counter-clockwise; sampled on the `rotate` rising edge.
- `left` in 1: left button level.
- `right` in 1: right button level.
- `op_valid` out 1: an operation is offered to the datapath.
- `op_code` out 3: operation code. 0 NOP, 1 LEFT, 2 RIGHT, 3 ROT_CW, 4 ROT_CCW, 5 DROP, 6 SPAWN.
- `op_ready` in 1: the datapath accepts the offered operation.
- `op_done` in 1: one-cycle pulse when the accepted operation finishes.
- `op_ok` in 1: valid with `op_done`. 1 = move applied, 0 = blocked.
- `busy` out 1: an operation is offered or in flight.
- `game_over` out 1: sticky; cleared only by reset.

## Operation
- **Edge capture**
  - The block registers the previous level of `left`, `right` and `rotate`.
  - A rising edge while `run`=1 sets the matching pending bit: `pend_left`, `pend_right` or `pend_rot`.
  - On a `rotate` edge, `rotate_direction` is latched into `rot_dir`.
  - Edges seen while `run`=0 or in GAME_OVER are discarded.
- **Pending merge:** one pending bit per type. A repeat edge while that bit is set is merged. For rotate, the latest `rot_dir` wins.
- **Gravity timer**
  - The counter increments only when `run`=1 and the state is not GAME_OVER; otherwise it is frozen.
  - At `GRAVITY_PERIOD-1` it wraps to 0 and sets `pend_drop`.
- **Pending clear:** a pending bit clears on the handshake cycle (`op_valid & op_ready`) of its operation. A same-type edge on that same cycle re-sets the bit; set wins.
- **State machine**
  - SELECT:
    - If `run`=0, stay.
    - Otherwise pick the highest-priority pending bit: SPAWN > ROT > LEFT > RIGHT > DROP. Load `op_code` and go to ISSUE.
    - With nothing pending, stay.
  - ISSUE:
    - `op_valid`=1, and `op_code` is held stable.
    - On `op_ready` go to WAIT.
    - `run` falling while in ISSUE does not withdraw the offer.
  - WAIT:
    - `op_valid`=0; wait for `op_done`.
    - DROP with `op_ok`=0 means the piece locks: set `pend_spawn`.
    - SPAWN with `op_ok`=0 goes to GAME_OVER.
    - All other cases return to SELECT.
  - GAME_OVER: `game_over`=1. All pending bits are cleared and held clear. The block is inert until reset.
- **Blocked moves:** LEFT, RIGHT and ROT with `op_ok`=0 are dropped silently, with no retry.

## Timing
- **Reset values**
  - State SELECT, counter 0, `rot_dir` 0.
  - All pending bits 0 except `pend_spawn`=1, so the first piece spawns.
  - `op_valid` 0, `op_code` 0, `busy` 0, `game_over` 0.
- **Outputs are registered.**
  - Button latency: a button level sampled 0 at edge N-1 and 1 at edge N sets pending after edge N. If SELECT is idle with nothing higher pending, `op_valid`=1 after edge N+1.
  - `op_valid` stays asserted until a cycle with `op_ready`=1. At most one operation is in flight.
  - `op_done` is ignored unless the state is WAIT. It is never expected on the handshake cycle itself.
  - `busy` = state is ISSUE or WAIT.
- **Reset mid-operation:** asserting `resetn` forces the reset values immediately (asynchronously). Any operation in flight is abandoned.

## Structure
- `tetris_pkg` holds:
  - the `op_code_t` enum (3 bits, codes above);
  - the `sched_state_t` enum;
  - board constants `BOARD_W`=10 and `BOARD_H`=20.
- `tetris_edge_latch` is the one sub-module: rising-edge detect plus a sticky pending bit, with set-over-clear priority. It is instantiated three times (left, right, rotate).
- The gravity counter and the FSM live in the top module.

## Test plan
Bench uses `GRAVITY_PERIOD`=8 and a datapath model with `op_ready`=1 and `op_done` one cycle after handshake, unless stated otherwise.
1. Release reset with `run`=1 → first op is `op_code`=6 (SPAWN). With no buttons pressed, `op_code`=5 (DROP) is offered every 8 cycles.
2. `left` and `rotate` (`rotate_direction`=0) rise on the same cycle → ROT_CCW (4) is issued first, then LEFT (1). No duplicate ops.
3. `op_ready`=0 held for 5 cycles during a LEFT offer → `op_valid`=1 and `op_code`=1 stable for all 5 cycles. `busy`=1 throughout.
4. DROP answered with `op_ok`=0 → next op is SPAWN (6). That SPAWN answered with `op_ok`=0 → `game_over`=1, and later edges are ignored.
5. `run`=0 for 20 cycles with `right` toggling → no op issued, counter frozen, no pending set. On `run`=1, DROP arrives 8 cycles after the last count.
6. Assert `resetn` while in WAIT → `op_valid`=0 and `busy`=0 immediately. After release, SPAWN is reissued.
